// File: rtl/key_cond_pkg.sv
// Shared types and helpers for the key_conditioner block.
package key_cond_pkg;

   typedef enum logic [1:0] {IDLE, HELD, DELAY, REPEAT} key_state_e;

   localparam int unsigned PRESS_CNT_W = 8;

   // Bits needed to count 0..max_val-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val <= 1) ? 1 : $clog2(max_val);
   endfunction

endpackage

// File: rtl/key_cond_channel.sv
// One key channel: 2-FF synchroniser, tick-sampled debounce, edge pulses and
// the auto-repeat state machine.
module key_cond_channel
   import key_cond_pkg::*;
#(
   parameter int unsigned stable_cnt_p   = 4,
   parameter int unsigned repeat_delay_p = 24,
   parameter int unsigned repeat_rate_p  = 6
) (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic key_i,
   input  logic tick_i,
   input  logic repeat_en_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic event_o
);

   localparam int unsigned DebW   = cnt_width(stable_cnt_p);
   localparam int unsigned RptMax = (repeat_delay_p > repeat_rate_p) ? repeat_delay_p : repeat_rate_p;
   localparam int unsigned RptW   = cnt_width(RptMax);
   localparam logic [DebW-1:0] DebLast   = DebW'(stable_cnt_p - 1);
   localparam logic [RptW-1:0] DelayLast = RptW'(repeat_delay_p - 1);
   localparam logic [RptW-1:0] RateLast  = RptW'(repeat_rate_p - 1);

   logic            r_sync1, r_sync2, r_level, r_press, r_release, r_event;
   logic [DebW-1:0] r_dcnt;
   logic [RptW-1:0] r_rcnt, w_rcnt_n;
   key_state_e      r_state, w_state_n;
   logic            w_flip, w_rise, w_fall, w_event_n;

   // Level flips on the stable_cnt_p-th consecutive differing tick sample.
   assign w_flip = tick_i && (r_sync2 != r_level) && (r_dcnt == DebLast);
   assign w_rise = w_flip && !r_level;
   assign w_fall = w_flip && r_level;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_dcnt    <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_sync1   <= key_i;
         r_sync2   <= r_sync1;
         r_press   <= w_rise;
         r_release <= w_fall;
         if (tick_i) begin
            if ((r_sync2 == r_level) || w_flip) r_dcnt <= '0;
            else                                r_dcnt <= r_dcnt + DebW'(1);
            if (w_flip) r_level <= ~r_level;
         end
      end
   end

   // Release takes priority over any repeat expiry on the same tick.
   always_comb begin
      w_state_n = r_state;
      w_rcnt_n  = r_rcnt;
      w_event_n = 1'b0;
      if (w_fall) begin
         w_state_n = IDLE;
         w_rcnt_n  = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_rise) begin
                  w_state_n = repeat_en_i ? DELAY : HELD;
                  w_rcnt_n  = '0;
                  w_event_n = 1'b1;
               end
            end
            HELD: w_state_n = HELD;
            DELAY: begin
               if (tick_i) begin
                  if (r_rcnt == DelayLast) begin
                     w_state_n = REPEAT;
                     w_rcnt_n  = '0;
                     w_event_n = 1'b1;
                  end else begin
                     w_rcnt_n = r_rcnt + RptW'(1);
                  end
               end
            end
            REPEAT: begin
               if (tick_i) begin
                  if (r_rcnt == RateLast) begin
                     w_rcnt_n  = '0;
                     w_event_n = 1'b1;
                  end else begin
                     w_rcnt_n = r_rcnt + RptW'(1);
                  end
               end
            end
            default: w_state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= IDLE;
         r_rcnt  <= '0;
         r_event <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_rcnt  <= w_rcnt_n;
         r_event <= w_event_n;
      end
   end

   assign level_o   = r_level;
   assign press_o   = r_press;
   assign release_o = r_release;
   assign event_o   = r_event;

endmodule

// File: rtl/key_conditioner.sv
// N-channel push-button front end: shared sample-tick divider plus per-channel
// conditioning. Optional per-channel press counters under KEY_CONDITIONER_STATS_EN.
module key_conditioner
   import key_cond_pkg::*;
#(
   parameter int unsigned            channels_p     = 5,
   parameter int unsigned            sample_div_p   = 50000,
   parameter int unsigned            stable_cnt_p   = 4,
   parameter int unsigned            repeat_delay_p = 24,
   parameter int unsigned            repeat_rate_p  = 6,
   parameter logic [channels_p-1:0]  repeat_mask_p  = '0,
   parameter bit                     active_low_p   = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic [channels_p-1:0] keys_i,
   output logic [channels_p-1:0] level_o,
   output logic [channels_p-1:0] press_o,
   output logic [channels_p-1:0] release_o,
   output logic [channels_p-1:0] event_o,
   output logic                  tick_o
`ifdef KEY_CONDITIONER_STATS_EN
   ,
   input  logic                              stats_clr_i,
   output logic [channels_p*PRESS_CNT_W-1:0] press_count_o
`endif
);

   localparam int unsigned     DivW    = cnt_width(sample_div_p);
   localparam logic [DivW-1:0] DivLast = DivW'(sample_div_p - 1);
   localparam logic [DivW-1:0] DivPre  = DivW'(sample_div_p - 2);

   logic [DivW-1:0]       r_div;
   logic                  r_tick;
   logic [channels_p-1:0] w_keys;

   // r_tick is high exactly while r_div sits at its last count.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_div  <= (r_div == DivLast) ? '0 : r_div + DivW'(1);
         r_tick <= (r_div == DivPre);
      end
   end

   assign tick_o = r_tick;
   assign w_keys = active_low_p ? ~keys_i : keys_i;

   for (genvar g = 0; g < int'(channels_p); g++) begin : g_ch
      key_cond_channel #(
         .stable_cnt_p   (stable_cnt_p),
         .repeat_delay_p (repeat_delay_p),
         .repeat_rate_p  (repeat_rate_p)
      ) u_ch (
         .clk_i       (clk_i),
         .reset_n_i   (reset_n_i),
         .key_i       (w_keys[g]),
         .tick_i      (r_tick),
         .repeat_en_i (repeat_mask_p[g]),
         .level_o     (level_o[g]),
         .press_o     (press_o[g]),
         .release_o   (release_o[g]),
         .event_o     (event_o[g])
      );
   end

`ifdef KEY_CONDITIONER_STATS_EN
   logic [channels_p-1:0][PRESS_CNT_W-1:0] r_press_cnt;

   // Saturating press counters; a clear beats a same-cycle increment.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_press_cnt <= '0;
      end else if (stats_clr_i) begin
         r_press_cnt <= '0;
      end else begin
         for (int c = 0; c < int'(channels_p); c++) begin
            if (press_o[c] && (r_press_cnt[c] != {PRESS_CNT_W{1'b1}}))
               r_press_cnt[c] <= r_press_cnt[c] + PRESS_CNT_W'(1);
         end
      end
   end

   assign press_count_o = r_press_cnt;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner (also exercises KEY_CONDITIONER_STATS_EN when defined).
module tb_key_conditioner;

   localparam int CH   = 5;
   localparam int DIV  = 4;
   localparam int STB  = 3;
   localparam int DLY  = 8;
   localparam int RATE = 2;
   localparam logic [CH-1:0] MASK = 5'b00001;

   logic          clk_i     = 1'b0;
   logic          reset_n_i = 1'b0;
   logic [CH-1:0] keys_i    = '0;
   logic [CH-1:0] level_o, press_o, release_o, event_o;
   logic          tick_o;
`ifdef KEY_CONDITIONER_STATS_EN
   logic            stats_clr_i = 1'b0;
   logic [CH*8-1:0] press_count_o;
`endif

   key_conditioner #(
      .channels_p     (CH),
      .sample_div_p   (DIV),
      .stable_cnt_p   (STB),
      .repeat_delay_p (DLY),
      .repeat_rate_p  (RATE),
      .repeat_mask_p  (MASK),
      .active_low_p   (1'b0)
   ) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .keys_i    (keys_i),
      .level_o   (level_o),
      .press_o   (press_o),
      .release_o (release_o),
      .event_o   (event_o),
      .tick_o    (tick_o)
`ifdef KEY_CONDITIONER_STATS_EN
      ,
      .stats_clr_i   (stats_clr_i),
      .press_count_o (press_count_o)
`endif
   );

   initial forever #5 clk_i = ~clk_i;

   // Reference model: cycle index since reset, key history, run lengths and ticks-held ages.
   int            cyc;
   logic [CH-1:0] hist1, hist2, seen;
   logic [CH-1:0] m_level, m_press, m_rel, m_ev;
   logic          m_tick, tick_now;
   int            run [CH];
   int            age [CH];
   int            m_cnt [CH];

   always @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cyc = 0; hist1 = '0; hist2 = '0;
         m_level = '0; m_press = '0; m_rel = '0; m_ev = '0; m_tick = 1'b0;
         for (int c = 0; c < CH; c++) begin run[c] = 0; age[c] = 0; m_cnt[c] = 0; end
      end else begin
         cyc++;
         tick_now = (cyc % DIV == 0);
         seen  = hist2;
         hist2 = hist1;
         hist1 = keys_i;
`ifdef KEY_CONDITIONER_STATS_EN
         for (int c = 0; c < CH; c++) begin
            if (stats_clr_i) m_cnt[c] = 0;
            else if (m_press[c] && m_cnt[c] < 255) m_cnt[c]++;
         end
`endif
         m_press = '0; m_rel = '0; m_ev = '0;
         m_tick = (cyc % DIV == DIV - 1);
         if (tick_now) begin
            for (int c = 0; c < CH; c++) begin
               if (seen[c] != m_level[c]) begin
                  run[c]++;
                  if (run[c] == STB) begin
                     run[c] = 0;
                     m_level[c] = ~m_level[c];
                     if (m_level[c]) begin m_press[c] = 1'b1; m_ev[c] = 1'b1; age[c] = 0; end
                     else m_rel[c] = 1'b1;
                  end
               end else begin
                  run[c] = 0;
               end
               if (!m_press[c] && !m_rel[c] && m_level[c] && MASK[c]) begin
                  age[c]++;
                  if (age[c] >= DLY && (age[c] - DLY) % RATE == 0) m_ev[c] = 1'b1;
               end
            end
         end
      end
   end

   int checks = 0;
   int errors = 0;
   int ev1_cnt = 0, rel1_cnt = 0, ch2_act = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic at_cyc(input int n);
      int guard = 0;
      while (cyc < n && guard < 20000) begin @(negedge clk_i); guard++; end
      if (cyc != n) chk("at_cyc_timeout", 64'(cyc), 64'(n));
   endtask

   logic [CH-1:0] tbl [6];
`ifdef KEY_CONDITIONER_STATS_EN
   logic [CH*8-1:0] exp_cnt;
`endif

   initial begin
      fork
         begin
            #1_000_000;
            $display("FAIL watchdog cyc=%0d", cyc);
            $fatal(1, "watchdog expired");
         end
      join_none

      // Per-cycle comparison against the model, plus activity tallies.
      fork
         forever begin
            @(negedge clk_i);
            if (reset_n_i) begin
               chk("level",   64'(level_o),   64'(m_level));
               chk("press",   64'(press_o),   64'(m_press));
               chk("release", 64'(release_o), 64'(m_rel));
               chk("event",   64'(event_o),   64'(m_ev));
               chk("tick",    64'(tick_o),    64'(m_tick));
`ifdef KEY_CONDITIONER_STATS_EN
               for (int c = 0; c < CH; c++) exp_cnt[c*8 +: 8] = 8'(m_cnt[c]);
               chk("press_count", 64'(press_count_o), 64'(exp_cnt));
`endif
               if (event_o[1])   ev1_cnt++;
               if (release_o[1]) rel1_cnt++;
               if (level_o[2] || press_o[2] || release_o[2] || event_o[2]) ch2_act++;
            end
         end
      join_none

      repeat (4) @(negedge clk_i);
      chk("rst_level", 64'(level_o), 64'd0);
      chk("rst_press", 64'(press_o), 64'd0);
      chk("rst_event", 64'(event_o), 64'd0);
      chk("rst_tick",  64'(tick_o),  64'd0);
      reset_n_i = 1'b1;

      // Channels 0 (repeating) and 1 (non-repeating) pressed together.
      at_cyc(2);  chk("tick_c2", 64'(tick_o), 64'd0);
      at_cyc(3);  chk("tick_c3", 64'(tick_o), 64'd1);
      at_cyc(9);  keys_i[0] = 1'b1; keys_i[1] = 1'b1;
      at_cyc(19); chk("lvl_pre", 64'(level_o), 64'd0);
      at_cyc(20);
      chk("press_20", 64'(press_o), 64'b00011);
      chk("event_20", 64'(event_o), 64'b00011);
      chk("level_20", 64'(level_o), 64'b00011);
      at_cyc(52); chk("rep1_52", 64'(event_o), 64'b00001);
      at_cyc(60); chk("rep2_60", 64'(event_o), 64'b00001);
      at_cyc(64); keys_i[0] = 1'b0;
      at_cyc(68); chk("rep3_68", 64'(event_o), 64'b00001);
      at_cyc(76);
      chk("rel_vs_rep_rel", 64'(release_o), 64'b00001);
      chk("rel_vs_rep_ev",  64'(event_o),   64'b00000);

      // Glitch pattern on channel 2; channel 1 released after 200 cycles.
      for (int t = 99; t <= 251; t++) begin
         at_cyc(t);
         if ((t - 99) % 16 == 0) keys_i[2] = 1'b1;
         if ((t - 99) % 16 == 8) keys_i[2] = 1'b0;
         if (t == 209) keys_i[1] = 1'b0;
         if (t == 220) chk("rel1_220", 64'(release_o), 64'b00010);
      end
      at_cyc(260);
      chk("ch1_events",   64'(ev1_cnt),  64'd1);
      chk("ch1_releases", 64'(rel1_cnt), 64'd1);
      chk("ch2_glitch",   64'(ch2_act),  64'd0);

      // Reset while channel 0 is auto-repeating, key still held.
      at_cyc(299); keys_i[0] = 1'b1;
      at_cyc(312); chk("press_312", 64'(press_o), 64'b00001);
      at_cyc(344); chk("rep_344",   64'(event_o), 64'b00001);
      at_cyc(352); chk("rep_352",   64'(event_o), 64'b00001);
      at_cyc(360); chk("lvl_360",   64'(level_o), 64'b00001);
      #2 reset_n_i = 1'b0;
      #1;
      chk("arst_level",   64'(level_o),   64'd0);
      chk("arst_press",   64'(press_o),   64'd0);
      chk("arst_release", 64'(release_o), 64'd0);
      chk("arst_event",   64'(event_o),   64'd0);
      chk("arst_tick",    64'(tick_o),    64'd0);
      repeat (3) @(negedge clk_i);
      reset_n_i = 1'b1;
      at_cyc(11); chk("relvl_11",   64'(level_o), 64'd0);
      at_cyc(12);
      chk("repress_12", 64'(press_o), 64'b00001);
      chk("reevent_12", 64'(event_o), 64'b00001);

      // Mixed multi-channel vectors, checked by the model only.
      tbl = '{5'b11001, 5'b11000, 5'b00110, 5'b10111, 5'b01000, 5'b00000};
      for (int i = 0; i < 6; i++) begin
         keys_i = tbl[i];
         repeat (48) @(negedge clk_i);
      end

`ifdef KEY_CONDITIONER_STATS_EN
      for (int i = 0; i < 300; i++) begin
         keys_i[3] = 1'b1; repeat (16) @(negedge clk_i);
         keys_i[3] = 1'b0; repeat (16) @(negedge clk_i);
      end
      repeat (4) @(negedge clk_i);
      chk("cnt_sat", 64'(press_count_o[31:24]), 64'd255);
      keys_i[3] = 1'b1;
      begin
         int guard = 0;
         while (!press_o[3] && guard < 100) begin @(negedge clk_i); guard++; end
         chk("clr_press_seen", 64'(press_o[3]), 64'd1);
      end
      stats_clr_i = 1'b1;
      @(negedge clk_i);
      stats_clr_i = 1'b0;
      chk("cnt_clr", 64'(press_count_o[31:24]), 64'd0);
      @(negedge clk_i);
      chk("cnt_clr_hold", 64'(press_count_o[31:24]), 64'd0);
      keys_i = '0;
      repeat (40) @(negedge clk_i);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
